// File: rtl/stopwatch_counter.sv
// ---------------------------------------------------------------------------
// stopwatch_counter
//   MM:SS BCD stopwatch core. Rising edges of the divider's seconds clock
//   become one-cycle ticks that advance the count (RUN), are ignored
//   (PAUSED), or bump a single selected field without carry (ADJUST).
//
// Parameters
//   MAX_MIN        minutes value at which MM:SS wraps to 00:00 (1..99)
//   START_RUNNING  1: RUN after reset, 0: PAUSED after reset
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   sec_clk_i      seconds clock level from the divider (clk_i domain)
//   pause_i        one-cycle pulse, toggles RUN/PAUSED
//   adj_i          level, 1 = adjust mode
//   sel_i          adjust field: 0 = seconds, 1 = minutes
//   min_tens_o     BCD minutes tens
//   min_ones_o     BCD minutes ones
//   sec_tens_o     BCD seconds tens (0..5)
//   sec_ones_o     BCD seconds ones
//   running_o      state == RUN
//   adjusting_o    state == ADJUST
//   wrap_o         one-cycle pulse on MAX_MIN:59 -> 00:00 in RUN
// ---------------------------------------------------------------------------
module stopwatch_counter #(
  parameter int MAX_MIN       = 59,
  parameter bit START_RUNNING = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sec_clk_i,
  input  logic       pause_i,
  input  logic       adj_i,
  input  logic       sel_i,
  output logic [3:0] min_tens_o,
  output logic [3:0] min_ones_o,
  output logic [3:0] sec_tens_o,
  output logic [3:0] sec_ones_o,
  output logic       running_o,
  output logic       adjusting_o,
  output logic       wrap_o
);

  typedef enum logic [1:0] {RUN, PAUSED, ADJUST} state_e;

  localparam state_e     RST_STATE = START_RUNNING ? RUN : PAUSED;
  // Minutes limit split into decimal digits so the compare is done in BCD.
  localparam logic [3:0] MAX_T     = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_O     = 4'(MAX_MIN % 10);

  state_e     state_q;
  logic       sec_q;
  logic [3:0] mt_q, mo_q, st_q, so_q;
  logic [3:0] mt_d, mo_d, st_d, so_d;
  logic       wrap_q, wrap_d;
  logic       tick, sec_max, min_max;

  // sec_q resets high to match the divider's reset level, so the first
  // cycle after reset never sees a false rising edge.
  assign tick    = sec_clk_i & ~sec_q;
  assign sec_max = (st_q == 4'd5) && (so_q == 4'd9);
  assign min_max = (mt_q == MAX_T) && (mo_q == MAX_O);

  // Next digit values; the decision uses the state before the edge, so a
  // tick that coincides with a state change is handled by the old state.
  always_comb begin
    mt_d   = mt_q;
    mo_d   = mo_q;
    st_d   = st_q;
    so_d   = so_q;
    wrap_d = 1'b0;
    if (tick) begin
      case (state_q)
        RUN: begin
          if (so_q != 4'd9) begin
            so_d = so_q + 4'd1;
          end else begin
            so_d = 4'd0;
            if (st_q != 4'd5) begin
              st_d = st_q + 4'd1;
            end else begin
              st_d = 4'd0;
              if (min_max) begin
                mt_d   = 4'd0;
                mo_d   = 4'd0;
                wrap_d = 1'b1;
              end else if (mo_q == 4'd9) begin
                mo_d = 4'd0;
                mt_d = mt_q + 4'd1;
              end else begin
                mo_d = mo_q + 4'd1;
              end
            end
          end
        end
        ADJUST: begin
          // Field-local increment: wraps at its own limit, never carries.
          if (sel_i) begin
            if (min_max) begin
              mt_d = 4'd0;
              mo_d = 4'd0;
            end else if (mo_q == 4'd9) begin
              mo_d = 4'd0;
              mt_d = mt_q + 4'd1;
            end else begin
              mo_d = mo_q + 4'd1;
            end
          end else begin
            if (sec_max) begin
              st_d = 4'd0;
              so_d = 4'd0;
            end else if (so_q == 4'd9) begin
              so_d = 4'd0;
              st_d = st_q + 4'd1;
            end else begin
              so_d = so_q + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RST_STATE;
      sec_q   <= 1'b1;
      mt_q    <= 4'd0;
      mo_q    <= 4'd0;
      st_q    <= 4'd0;
      so_q    <= 4'd0;
      wrap_q  <= 1'b0;
    end else begin
      sec_q  <= sec_clk_i;
      mt_q   <= mt_d;
      mo_q   <= mo_d;
      st_q   <= st_d;
      so_q   <= so_d;
      wrap_q <= wrap_d;
      // adj outranks pause in both non-adjust states.
      case (state_q)
        RUN:     if (adj_i) state_q <= ADJUST;
                 else if (pause_i) state_q <= PAUSED;
        PAUSED:  if (adj_i) state_q <= ADJUST;
                 else if (pause_i) state_q <= RUN;
        ADJUST:  if (!adj_i) state_q <= PAUSED;
        default: state_q <= RST_STATE;
      endcase
    end
  end

  assign min_tens_o  = mt_q;
  assign min_ones_o  = mo_q;
  assign sec_tens_o  = st_q;
  assign sec_ones_o  = so_q;
  assign running_o   = (state_q == RUN);
  assign adjusting_o = (state_q == ADJUST);
  assign wrap_o      = wrap_q;

endmodule
